dino_game_ctrl: RTL and testbench

Game-state controller sitting directly downstream of the dino jump-height generator. It consumes the dino height `dino_y` and the current obstacle position, and detects collisions. It runs the IDLE/RUN/HIT/OVER state machine, keeps the score and high score, and drives the `freeze` line back into the jump generator and the obstacle stage. Everything runs on the 16 Hz game tick.

---
 rtl/dino_game_ctrl_pkg.sv | 42 ++++
 rtl/dino_game_ctrl_bcd_counter4.sv | 54 +++++
 rtl/dino_game_ctrl.sv | 138 +++++++++++++
 tb/tb_dino_game_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dino_game_ctrl_pkg.sv
// ============================================================================
// Module      : dino_pkg
// Description : Shared types and constants for the dino game controller and
//               the obstacle stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    typedef logic [15:0] bcd4_t;

    localparam int C_OBS_W        = 8;
    localparam int C_DEF_DINO_X_L = 16;
    localparam int C_DEF_DINO_X_R = 24;
    localparam bcd4_t C_BCD_MAX   = 16'h9999;

    // Digit-wise magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input bcd4_t a, input bcd4_t b);
        logic res;
        logic done;
        res  = 1'b0;
        done = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
                res  = (a[4*i +: 4] > b[4*i +: 4]);
                done = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dino_game_ctrl_bcd_counter4.sv
// ============================================================================
// Module      : bcd_counter4
// Description : Four-digit BCD up-counter with clear, saturating at 9999.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter4
    import dino_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  inc_i,
    output bcd4_t count_o
);

    bcd4_t count_q;
    bcd4_t count_d;

    always_comb begin
        logic       carry;
        logic [3:0] digit;
        count_d = count_q;
        carry   = inc_i && (count_q != C_BCD_MAX);
        for (int i = 0; i < 4; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clr_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/dino_game_ctrl.sv
// ============================================================================
// Module      : dino_game_ctrl
// Description : Dino game state machine: collision detect, score, high score
//               and freeze control, all on the 16 Hz game tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int DINO_X_L  = C_DEF_DINO_X_L,
    parameter int DINO_X_R  = C_DEF_DINO_X_R,
    parameter int HIT_TICKS = 8,
    parameter int SCORE_DIV = 4
) (
    input  logic        clk_16Hz,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  dino_y,
    input  logic [7:0]  obs_x,
    input  logic [6:0]  obs_h,
    input  logic        obs_valid,
    output logic        freeze,
    output logic [1:0]  state,
    output logic        blink,
    output logic [15:0] score,
    output logic [15:0] hi_score
);

    localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int HCNT_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    state_e              state_q;
    logic                freeze_q;
    logic                blink_q;
    logic                start_q;
    logic [DIV_W-1:0]    div_q;
    logic [HCNT_W-1:0]   hcnt_q;
    bcd4_t               hi_q;
    bcd4_t               w_score;

    logic       w_start_rise;
    logic [8:0] w_obs_r;
    logic       w_hit;
    logic       w_div_wrap;
    logic       w_score_clr;
    logic       w_score_inc;

    assign w_start_rise = start & ~start_q;

    // Right edge is computed in 9 bits so obstacles near column 255 cannot wrap.
    assign w_obs_r = {1'b0, obs_x} + 9'(C_OBS_W);
    assign w_hit   = obs_valid
                   && ({1'b0, obs_x} <= 9'(DINO_X_R))
                   && (w_obs_r > 9'(DINO_X_L))
                   && (dino_y < obs_h);

    assign w_div_wrap  = (div_q == DIV_W'(SCORE_DIV - 1));
    assign w_score_clr = w_start_rise && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    // A collision tick drops any score step that would have landed on it.
    assign w_score_inc = (state_q == ST_RUN) && !w_hit && w_div_wrap;

    bcd_counter4 u_score (
        .clk     (clk_16Hz),
        .rst     (rst),
        .clr_i   (w_score_clr),
        .inc_i   (w_score_inc),
        .count_o (w_score)
    );

    always_ff @(posedge clk_16Hz) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            freeze_q <= 1'b1;
            blink_q  <= 1'b0;
            start_q  <= 1'b0;
            div_q    <= '0;
            hcnt_q   <= '0;
            hi_q     <= '0;
        end else begin
            start_q <= start;
            case (state_q)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        state_q  <= ST_RUN;
                        freeze_q <= 1'b0;
                        div_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_hit) begin
                        state_q  <= ST_HIT;
                        freeze_q <= 1'b1;
                        blink_q  <= 1'b1;
                        hcnt_q   <= HCNT_W'(HIT_TICKS - 1);
                    end else if (w_div_wrap) begin
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_HIT: begin
                    if (hcnt_q == '0) begin
                        state_q <= ST_OVER;
                        blink_q <= 1'b0;
                        if (bcd_gt(w_score, hi_q)) begin
                            hi_q <= w_score;
                        end
                    end else begin
                        hcnt_q  <= hcnt_q - 1'b1;
                        blink_q <= ~blink_q;
                    end
                end
                ST_OVER: begin
                    if (w_start_rise) begin
                        state_q  <= ST_RUN;
                        freeze_q <= 1'b0;
                        div_q    <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    freeze_q <= 1'b1;
                end
            endcase
        end
    end

    assign freeze   = freeze_q;
    assign state    = state_q;
    assign blink    = blink_q;
    assign score    = w_score;
    assign hi_score = hi_q;

endmodule

`default_nettype wire

// File: tb/tb_dino_game_ctrl.sv
// ============================================================================
// Module      : tb_dino_game_ctrl
// Description : Self-checking bench for dino_game_ctrl with a behavioural
//               game model and directed scenarios on two configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dino_game_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] dino_y;
    logic [7:0] obs_x;
    logic [6:0] obs_h;
    logic       obs_valid;

    logic        frz0, blk0, frz1, blk1;
    logic [1:0]  st0, st1;
    logic [15:0] sc0, hi0, sc1, hi1;

    int checks   = 0;
    int failures = 0;

    // Instance 0: default parameters. Instance 1: shifted hitbox, fast score.
    dino_game_ctrl u_dut0 (
        .clk_16Hz (clk), .rst (rst), .start (start), .dino_y (dino_y),
        .obs_x (obs_x), .obs_h (obs_h), .obs_valid (obs_valid),
        .freeze (frz0), .state (st0), .blink (blk0), .score (sc0), .hi_score (hi0)
    );

    dino_game_ctrl #(.DINO_X_L(17), .SCORE_DIV(1)) u_dut1 (
        .clk_16Hz (clk), .rst (rst), .start (start), .dino_y (dino_y),
        .obs_x (obs_x), .obs_h (obs_h), .obs_valid (obs_valid),
        .freeze (frz1), .state (st1), .blink (blk1), .score (sc1), .hi_score (hi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  p_xl[2] = '{16, 17};
    int  p_div[2] = '{4, 1};
    int  m_mode[2], m_score[2], m_hi[2], m_ticks[2], m_hitleft[2];
    bit  m_blink[2], m_prev_start[2];
    bit  m_valid = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit collides(input int k);
        int left;
        left = int'(obs_x);
        return obs_valid && (left <= 24) && (left + 8 > p_xl[k]) && (int'(dino_y) < int'(obs_h));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit rise;
            if (rst) begin
                m_mode[k] = 0; m_score[k] = 0; m_hi[k] = 0; m_ticks[k] = 0;
                m_hitleft[k] = 0; m_blink[k] = 0; m_prev_start[k] = 0;
            end else begin
                rise = start && !m_prev_start[k];
                m_prev_start[k] = start;
                if (m_mode[k] == 0 || m_mode[k] == 3) begin
                    if (rise) begin
                        m_mode[k] = 1; m_score[k] = 0; m_ticks[k] = 0;
                    end
                end else if (m_mode[k] == 1) begin
                    if (collides(k)) begin
                        m_mode[k] = 2; m_hitleft[k] = 8; m_blink[k] = 1;
                    end else begin
                        m_ticks[k]++;
                        if (m_ticks[k] == p_div[k]) begin
                            m_ticks[k] = 0;
                            if (m_score[k] < 9999) m_score[k]++;
                        end
                    end
                end else begin
                    m_hitleft[k]--;
                    if (m_hitleft[k] == 0) begin
                        m_mode[k] = 3; m_blink[k] = 0;
                        if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
                    end else begin
                        m_blink[k] = !m_blink[k];
                    end
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                logic [36:0] act, exp;
                act = (k == 0) ? {st0, frz0, blk0, sc0, hi0} : {st1, frz1, blk1, sc1, hi1};
                exp = {2'(m_mode[k]), (m_mode[k] != 1), m_blink[k], to_bcd(m_score[k]), to_bcd(m_hi[k])};
                checks++;
                if (act !== exp) begin
                    failures++;
                    if (failures < 30)
                        $display("FAIL model_dut%0d t=%0t actual={st,frz,blk,score,hi}=%h required=%h",
                                 k, $time, act, exp);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic press();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic probe(input logic [7:0] x, input logic [6:0] y, input logic [6:0] h,
                         input bit exp0, input bit exp1);
        obs_x = x; dino_y = y; obs_h = h; obs_valid = 1'b1;
        tick(1);
        obs_valid = 1'b0;
        check($sformatf("probe_x%0d_dut0", x), 16'(st0), exp0 ? 16'd2 : 16'd1);
        check($sformatf("probe_x%0d_dut1", x), 16'(st1), exp1 ? 16'd2 : 16'd1);
        tick(10);
        press();
        check($sformatf("probe_x%0d_restart", x), 16'(st0), 16'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dino_y = '0; obs_x = 8'd100; obs_h = '0; obs_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("idle_state", 16'(st0), 16'd0);
        check("idle_freeze", 16'(frz0), 16'd1);
        check("idle_score", sc0, 16'h0000);
        check("idle_hi", hi0, 16'h0000);

        press();
        check("start_state", 16'(st0), 16'd1);
        check("start_freeze", 16'(frz0), 16'd0);
        tick(40);
        check("run40_score", sc0, 16'h0010);

        obs_x = 8'd20; obs_h = 7'd12; dino_y = 7'd12; obs_valid = 1'b1;
        tick(3);
        check("equal_height_no_hit", 16'(st0), 16'd1);
        dino_y = 7'd5;
        tick(1);
        obs_valid = 1'b0;
        check("hit_state", 16'(st0), 16'd2);
        check("hit_freeze", 16'(frz0), 16'd1);
        check("hit_drops_wrap_inc", sc0, 16'h0010);
        check("blink_0", 16'(blk0), 16'd1);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            check($sformatf("blink_%0d", i), 16'(blk0), (i % 2 == 0) ? 16'd1 : 16'd0);
            check($sformatf("hit_hold_%0d", i), 16'(st0), 16'd2);
        end
        tick(1);
        check("over_state", 16'(st0), 16'd3);
        check("over_blink", 16'(blk0), 16'd0);
        check("over_hi", hi0, 16'h0010);
        check("over_hi_dut1", hi1, 16'h0043);

        press();
        probe(8'd25,  7'd5, 7'd12, 1'b0, 1'b0);
        probe(8'd24,  7'd5, 7'd12, 1'b1, 1'b1);
        probe(8'd8,   7'd5, 7'd12, 1'b0, 1'b0);
        probe(8'd9,   7'd5, 7'd12, 1'b1, 1'b0);
        probe(8'd255, 7'd5, 7'd12, 1'b0, 1'b0);

        obs_x = 8'd20; dino_y = 7'd5; obs_h = 7'd12; obs_valid = 1'b1;
        tick(1);
        obs_valid = 1'b0;
        start = 1'b1;
        tick(12);
        check("held_start_over", 16'(st0), 16'd3);
        start = 1'b0;
        tick(1);
        press();
        check("repress_state", 16'(st0), 16'd1);
        check("repress_score", sc0, 16'h0000);

        tick(10010);
        check("sat_score_dut1", sc1, 16'h9999);
        check("long_run_dut0", sc0, 16'h2502);

        obs_x = 8'd20; dino_y = 7'd5; obs_h = 7'd12; obs_valid = 1'b1;
        tick(1);
        obs_valid = 1'b0;
        tick(3);
        check("pre_rst_hit", 16'(st0), 16'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_state", 16'(st0), 16'd0);
        check("rst_freeze", 16'(frz0), 16'd1);
        check("rst_blink", 16'(blk0), 16'd0);
        check("rst_score", sc0, 16'h0000);
        check("rst_hi", hi0, 16'h0000);
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
